alu_op_driver: RTL

ALU_OP_DRIVER -- requirements
Module: alu_op_driver

---
 rtl/alu_op_driver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_op_driver.sv
// alu_op_driver: buffers ALU commands in a small FIFO, drives each one's operands onto an
// external combinational ALU, waits SETTLE cycles, then captures the result and holds it
// until the consumer accepts it.
module alu_op_driver #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [4:0]             cmd_a,
    input  logic [4:0]             cmd_b,
    input  logic [3:0]             cmd_s,
    output logic [4:0]             A,
    output logic [4:0]             B,
    output logic [3:0]             S,
    input  logic [4:0]             Alu,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4:0]             res_data,
    output logic [3:0]             res_s,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned SetW = $clog2(SETTLE) + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef logic [SetW-1:0] set_t;

    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
        logic [3:0] s;
    } cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StHold
    } state_e;

    // FIFO storage and bookkeeping
    cmd_t   mem_q [DEPTH];
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    cnt_t   count_q, count_d;

    // Sequencer state
    state_e     state_q, state_d;
    set_t       settle_q, settle_d;
    logic [4:0] a_q, a_d;
    logic [4:0] b_q, b_d;
    logic [3:0] s_q, s_d;
    logic       res_valid_q, res_valid_d;
    logic [4:0] res_data_q, res_data_d;
    logic [3:0] res_s_q, res_s_d;

    logic push;
    logic pop;
    cmd_t head;

    assign cmd_ready = (count_q < cnt_t'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // Only an idle sequencer consumes from the FIFO; a full FIFO never stalls it.
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // FIFO pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of 2)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer next-state: load operands on pop, settle, capture, hold for handshake
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_s_d     = res_s_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    a_d      = head.a;
                    b_d      = head.b;
                    s_d      = head.s;
                    settle_d = '0;
                    state_d  = StDrive;
                end
            end
            StDrive: begin
                settle_d = settle_q + set_t'(1);
                // Operands have been stable for SETTLE cycles by the end of this cycle.
                if (settle_q == set_t'(SETTLE - 1)) begin
                    res_data_d  = Alu;
                    res_s_d     = s_q;
                    res_valid_d = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; reset wins over any push, pop or handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            settle_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_s_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            settle_q    <= settle_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_s_q     <= res_s_d;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, s: cmd_s};
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign S          = s_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_s      = res_s_q;
    assign busy       = (state_q != StIdle);
    assign fifo_count = count_q;

endmodule
